icache_nway: RTL
================

ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 The parameter WAYS, default 4, SHALL set associativity; the legal values are 2 and 4.
REQ-002 The parameter SETS, default 64, SHALL set the sets per way; it is a power of 2, from 2 to 256.
REQ-003 The parameter LINE_WORDS, default 8, SHALL set the 32-bit words per line; it is a power of 2, from 2 to 16.
REQ-004 The module SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all logic is on its rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- req_valid, in, 1: fetch request.
- req_addr, in, 32: physical fetch address; bits [1:0] are ignored.
- req_ready, out, 1: request accepted when req_valid and req_ready are both high.
- resp_valid, out, 1: one-cycle pulse; resp_instr is valid.
- resp_instr, out, 32: fetched instruction word.
- mem_req_valid, out, 1: line refill request.
- mem_req_addr, out, 32: line-aligned refill address.
- mem_req_ready, in, 1: refill request accepted.
- mem_rsp_valid, in, 1: refill data beat valid.
- mem_rsp_data, in, 32: refill beat, ascending word order.
- flush, in, 1: invalidate the whole cache (fence.i).
- busy, out, 1: high in every state except IDLE.

Function
REQ-005 Address split: OFF = log2(LINE_WORDS) bits at [OFF+1:2]; IDX = log2(SETS) bits directly above; tag = the remaining upper bits. With the defaults: offset [4:2], index [10:5], tag [31:11].
REQ-006 Storage per way: a data array, a tag array and a valid-bit flop per set. Per set: a replacement state of WAYS-1 tree-PLRU bits (1 bit when WAYS=2).
REQ-007 States are IDLE, LOOKUP, MISS_REQ, REFILL, RESP and FLUSH; every state not listed in a transition goes to IDLE.
REQ-008 IDLE: req_ready=1. An accepted request registers its address and goes to LOOKUP. Otherwise, flush or a pending flush goes to FLUSH.
REQ-009 LOOKUP: hit = valid and tag equal in exactly one way.
- On a hit: resp_valid=1, resp_instr = the addressed word, PLRU points away from the hit way, req_ready=1.
- On a hit with a new request accepted: stay in LOOKUP, for back-to-back hits at 1 per cycle.
- On a hit with no new request accepted: go to IDLE.
- On a miss: req_ready=0; go to MISS_REQ.
REQ-010 Hit latency SHALL be exactly 1 cycle from acceptance to resp_valid.
REQ-011 Victim selection, evaluated on entering MISS_REQ:
- the lowest-numbered invalid way, if any;
- otherwise the way selected by the set's PLRU.
REQ-012 MISS_REQ: mem_req_valid=1 and mem_req_addr = {tag, index, OFF+2 zero bits}, both held stable until mem_req_ready; on the handshake go to REFILL.
REQ-013 REFILL: every mem_rsp_valid beat writes word k of the victim line (k from 0 to LINE_WORDS-1); the beat whose k equals the request offset is also captured for the response.
- Cycles without mem_rsp_valid stall without side effect.
- The victim's valid bit is cleared on the first beat.
REQ-014 After the last beat, the victim's tag is written, its valid bit is set, PLRU is updated as for a hit, and the state goes to RESP.
REQ-015 RESP: resp_valid=1 with the captured word for one cycle, then the state goes to IDLE. Miss latency = 2 + mem_req wait + beat cycles.
REQ-016 A flush asserted in any state other than IDLE or FLUSH SHALL be latched as pending and serviced from IDLE after the current operation completes. The refilled line is then invalidated by the flush.
REQ-017 FLUSH: clears the valid bits of all ways and all PLRU bits for one set per cycle, in index order 0 to SETS-1, taking SETS cycles; then the state goes to IDLE. req_ready=0 throughout. A flush during FLUSH is absorbed.
REQ-018 resp_valid SHALL never be asserted without a corresponding accepted request, and SHALL be asserted exactly once per accepted request, in order.
REQ-019 mem_rsp_valid outside REFILL SHALL be ignored.
REQ-020 Tag multi-hit cannot occur; the implementation gives priority to the lowest-numbered way.

Reset
REQ-021 When rst_n=0 at a clock edge, the next state SHALL be:
- state IDLE, all valid bits 0, all PLRU bits 0, flush pending 0;
- req_ready=1, resp_valid=0, resp_instr=0, mem_req_valid=0, mem_req_addr=0, busy=0.
REQ-022 Reset asserted mid-REFILL or mid-FLUSH SHALL abort the operation. No line is valid afterwards, and later beats are ignored.
REQ-023 Data and tag array contents need no reset.

Verification (WAYS=4, SETS=64, LINE_WORDS=8)
REQ-024 Cold miss:
- Stimulus: request 0x0000_1008; the memory accepts after 2 cycles and returns beats 0xA0..0xA7 with no gaps.
- Required: mem_req_addr=0x0000_1000; resp_instr=0xA2; resp_valid exactly 1 cycle after the last beat.
REQ-025 Back-to-back hits:
- Stimulus: requests 0x1000, 0x1004, 0x101C on consecutive cycles after REQ-024.
- Required: resp_valid on 3 consecutive cycles with 0xA0, 0xA1, 0xA7; no mem_req_valid.
REQ-026 Replacement:
- Stimulus: fill index 0 with tags T0..T3 in order, touch T0, then miss on T4.
- Required: T1's way is replaced; T0, T2 and T3 still hit.
REQ-027 Flush while busy:
- Stimulus: pulse flush during REFILL.
- Required: the refill response completes; busy stays high for exactly 64 further FLUSH cycles; a subsequent request to the same line misses.
REQ-028 Reset mid-refill:
- Stimulus: drive rst_n=0 after beat 3, then re-request the same address.
- Required: all outputs at reset values; the re-request misses and issues a new mem_req.
REQ-029 Stalled beats:
- Stimulus: insert 5 idle cycles between beats 4 and 5, and pulse mem_rsp_valid while IDLE.
- Required: correct line contents; the IDLE pulse has no effect.

Source files
------------

// File: rtl/icache_nway.sv
// Set-associative instruction cache with tree-PLRU replacement and blocking whole-line refill.
// Latency: a hit responds 1 cycle after acceptance (back-to-back hits at 1/cycle); a miss takes 2 + mem_req wait + beat cycles.
// Backpressure: req_ready is low during miss/refill/response/flush; refill stalls on cycles without mem_rsp_valid.
module icache_nway #(
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_instr,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        flush,
    output logic        busy
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam int PL_W  = WAYS - 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESP, S_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [29:0]      addr_q, addr_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic [31:0]      word_q, word_d;
    logic             flush_pend_q, flush_pend_d;
    logic [IDX_W-1:0] fidx_q, fidx_d;
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  valid_d [SETS];
    logic [PL_W-1:0]  plru_q [SETS];
    logic [PL_W-1:0]  plru_d [SETS];

    logic [31:0]      data_mem [WAYS][SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem [WAYS][SETS];
    logic             data_we, tag_we;

    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, inv_way;
    logic [31:0]      hit_word;
    logic             unused_addr_bits;

    // Byte-within-word bits never select anything.
    assign unused_addr_bits = ^req_addr[1:0];

    assign a_off = addr_q[OFF_W-1:0];
    assign a_idx = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign a_tag = addr_q[29:OFF_W+IDX_W];
    assign busy  = (state_q != S_IDLE);

    // Tree PLRU: bit 0 is the root and splits on way bit 0 (even vs odd ways);
    // bit 1 chooses within the even ways, bit 2 within the odd ways.
    // Each bit names the side to evict next. With two ways only bit 0 exists.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] p);
        logic [2:0] t;
        logic [1:0] v;
        t = 3'(p);
        v = {(t[0] ? t[2] : t[1]), t[0]};
        return WAY_W'(v);
    endfunction

    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] p, input logic [WAY_W-1:0] w);
        logic [2:0] t;
        logic [1:0] u;
        t = 3'(p);
        u = 2'(w);
        t[0] = ~u[0];
        if (u[0]) t[2] = ~u[1];
        else      t[1] = ~u[1];
        return PL_W'(t);
    endfunction

    // Tag compare (lowest way wins) and lowest invalid way of the addressed set.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[a_idx][w] && (tag_mem[w][a_idx] == a_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[a_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        hit_word = data_mem[hit_way][{a_idx, a_off}];
    end

    // Next-state, bookkeeping updates and outputs.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        victim_d      = victim_q;
        beat_d        = beat_q;
        word_d        = word_q;
        flush_pend_d  = flush_pend_q;
        fidx_d        = fidx_q;
        valid_d       = valid_q;
        plru_d        = plru_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_instr    = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        data_we       = 1'b0;
        tag_we        = 1'b0;

        // A fence.i arriving mid-operation is remembered and run from IDLE.
        if (flush && state_q != S_IDLE && state_q != S_FLUSH) flush_pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr[31:2];
                    state_d = S_LOOKUP;
                    if (flush) flush_pend_d = 1'b1;
                end else if (flush || flush_pend_q) begin
                    fidx_d       = '0;
                    flush_pend_d = 1'b0;
                    state_d      = S_FLUSH;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_valid    = 1'b1;
                    resp_instr    = hit_word;
                    req_ready     = 1'b1;
                    plru_d[a_idx] = plru_touch(plru_q[a_idx], hit_way);
                    if (req_valid) addr_d  = req_addr[31:2];
                    else           state_d = S_IDLE;
                end else begin
                    victim_d = inv_found ? inv_way : plru_victim(plru_q[a_idx]);
                    beat_d   = '0;
                    state_d  = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {a_tag, a_idx, {(OFF_W+2){1'b0}}};
                if (mem_req_ready) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (mem_rsp_valid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + OFF_W'(1);
                    if (beat_q == a_off) word_d = mem_rsp_data;
                    if (beat_q == '0) valid_d[a_idx][victim_q] = 1'b0;
                    if (beat_q == OFF_W'(LINE_WORDS-1)) begin
                        tag_we                   = 1'b1;
                        valid_d[a_idx][victim_q] = 1'b1;
                        plru_d[a_idx]            = plru_touch(plru_q[a_idx], victim_q);
                        state_d                  = S_RESP;
                    end
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_instr = word_q;
                state_d    = S_IDLE;
            end
            S_FLUSH: begin
                valid_d[fidx_q] = '0;
                plru_d[fidx_q]  = '0;
                fidx_d          = fidx_q + IDX_W'(1);
                if (fidx_q == IDX_W'(SETS-1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, valid bits and PLRU bits with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            victim_q     <= '0;
            beat_q       <= '0;
            word_q       <= '0;
            flush_pend_q <= 1'b0;
            fidx_q       <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            victim_q     <= victim_d;
            beat_q       <= beat_d;
            word_q       <= word_d;
            flush_pend_q <= flush_pend_d;
            fidx_q       <= fidx_d;
            valid_q      <= valid_d;
            plru_q       <= plru_d;
        end
    end

    // Line data and tag storage; contents are qualified by valid bits so need no reset.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[victim_q][{a_idx, beat_q}] <= mem_rsp_data;
        if (tag_we)  tag_mem[victim_q][a_idx] <= a_tag;
    end
endmodule
